mux8_bus_arbiter: RTL and testbench
===================================

# mux8_bus_arbiter

Round-robin arbiter that shares one 8:1 one-bit-per-lane datapath mux between eight requesters. It registers a one-hot grant and the matching 3-bit mux select, holds the grant until the owner releases or a hold limit expires, and inserts one turnaround cycle between owners. It sits directly in front of the shared bus mux in the processor datapath and drives that mux's select input.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles one owner may hold the grant; 0 = unlimited; legal range 0..255
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  8  request per requester, level-sensitive; bit i = requester i
- done  input  1  single-cycle release pulse from current owner
- gnt  output  8  registered one-hot grant; all-zero when bus idle
- sel  output  3  registered binary index of granted requester, drives mux select
- busy  output  1  registered; high while any grant is active (equals OR of gnt)

## Operation
- Two states: IDLE, GRANT. Reset state IDLE.
- Reset (rst high at a rising edge): gnt=0, sel=0, busy=0, state=IDLE, priority pointer ptr=0, hold counter=0. Reset wins over every other event, including mid-grant.
- IDLE: if req != 0, pick winner w = first set bit of req scanning ptr, ptr+1, ..., ptr+7 (mod 8). Next cycle: gnt=1<<w, sel=w, busy=1, state=GRANT, ptr=(w+1) mod 8, counter=1. If req == 0, stay IDLE, outputs unchanged (all zero, sel holds last value).
- GRANT: release condition is any of: done=1; req[sel]=0; MAX_HOLD!=0 and counter==MAX_HOLD. On release: next cycle gnt=0, busy=0, state=IDLE, sel holds last value. Otherwise counter increments (saturating at 255 when MAX_HOLD=0); gnt/sel unchanged.
- done asserted in IDLE is ignored. Requests from other requesters during GRANT are ignored; no preemption.
- sel changes only on the same edge that asserts a new grant; never changes while busy=1.
- Pointer arithmetic: 3-bit wrap, 7+1 = 0.

## Timing
- Request-to-grant latency: req sampled in IDLE at edge N → gnt/sel/busy valid after edge N (visible cycle N+1). Combinational path req→gnt is forbidden; outputs are flops.
- Release latency: release condition true at edge M → gnt=0 after edge M.
- Turnaround: after release, exactly one IDLE cycle with gnt=0 before the next grant, even if requests are pending. Minimum grant-to-grant spacing for back-to-back owners = hold length + 1 cycle.
- Hold limit: with MAX_HOLD=K (K≥1) and no voluntary release, grant is high for exactly K cycles.
- Simultaneous done and hold-limit expiry: single release, identical behaviour.
- rst asserted mid-grant: gnt=0, busy=0 after that edge; ptr returns to 0.

## Test plan
- Reset: hold rst 2 cycles with req=8'hFF → gnt=0, sel=0, busy=0; release rst → first grant gnt=8'h01, sel=0 one cycle later.
- Round-robin: req=8'hFF constant, owner pulses done 2 cycles after each grant → grant order 0,1,2,...,7,0 with one idle cycle between grants; sel tracks index.
- Skip/wrap: after grant to 6, req=8'h21 → next grant requester 0 (scan 7,0), then requester 5; ptr wraps 7→0.
- Hold limit: MAX_HOLD=4, req=8'h08 held, done never asserted → gnt=8'h08 for exactly 4 cycles, 1 idle cycle, re-grant to 3.
- Request drop and stray done: owner 2 drops req[2] mid-grant → gnt=0 next cycle; done pulsed in IDLE with req=0 → no state change.
- Reset mid-grant: grant to requester 4, assert rst → gnt=0, busy=0 next cycle; with req=8'h11 after reset, next winner is 0 (ptr reset), not 4.

Source files
------------

// File: rtl/mux8_bus_arbiter.sv
// mux8_bus_arbiter
// Round-robin owner selection for a shared 8:1 one-bit-per-lane bus mux.
// Grants are one-hot and registered, together with the binary mux select.
// An owner keeps the bus until it pulses done, drops its request, or runs
// into the optional hold limit. Every release is followed by one idle cycle
// before the next owner is granted. Requests from other requesters are not
// looked at while a grant is active, so there is no preemption.

module mux8_bus_arbiter #(
   parameter int unsigned MAX_HOLD = 16   // 0 = unlimited, otherwise 1..255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] sel,
   output logic       busy
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // Hold limit as an 8-bit compare value. A zero limit disables the check,
   // and the counter then just saturates.
   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
   localparam bit         HOLD_EN  = (MAX_HOLD != 32'd0);

   // Round-robin scan: return {found, index} of the first set request bit,
   // starting at position p and wrapping modulo 8.
   function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic [2:0] idx;
      logic       found;
      logic [2:0] win;
      found = 1'b0;
      win   = 3'd0;
      for (int i = 0; i < 8; i++) begin
         idx = p + 3'(i);
         if (!found && r[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      return {found, win};
   endfunction

   state_t     state_r,  state_nxt;
   logic [2:0] ptr_r,    ptr_nxt;
   logic [7:0] cnt_r,    cnt_nxt;
   logic [7:0] gnt_r,    gnt_nxt;
   logic [2:0] sel_r,    sel_nxt;
   logic       busy_r,   busy_nxt;

   logic       found_s;
   logic [2:0] win_s;
   logic       limit_s;
   logic       release_s;

   // Winner search and release-condition decode.
   always_comb begin
      found_s   = 1'b0;
      win_s     = 3'd0;
      limit_s   = 1'b0;
      release_s = 1'b0;
      {found_s, win_s} = rr_pick(req, ptr_r);
      if (HOLD_EN) begin
         limit_s = (cnt_r == HOLD_LIM);
      end else begin
         limit_s = 1'b0;
      end
      release_s = done || !req[sel_r] || limit_s;
   end

   // State register plus all registered outputs, with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         ptr_r   <= 3'd0;
         cnt_r   <= 8'd0;
         gnt_r   <= 8'd0;
         sel_r   <= 3'd0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt;
         ptr_r   <= ptr_nxt;
         cnt_r   <= cnt_nxt;
         gnt_r   <= gnt_nxt;
         sel_r   <= sel_nxt;
         busy_r  <= busy_nxt;
      end
   end

   // Next-state decision: grant on any request, drop back on any release.
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               state_nxt = ST_GRANT;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (release_s) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_GRANT;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Next values for grant, select, busy, pointer and hold counter.
   // sel is only rewritten together with a new grant, so it never moves
   // while the bus is owned.
   always_comb begin
      gnt_nxt  = gnt_r;
      sel_nxt  = sel_r;
      busy_nxt = busy_r;
      ptr_nxt  = ptr_r;
      cnt_nxt  = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               gnt_nxt  = 8'd1 << win_s;
               sel_nxt  = win_s;
               busy_nxt = 1'b1;
               ptr_nxt  = win_s + 3'd1;
               cnt_nxt  = 8'd1;
            end else begin
               gnt_nxt  = 8'd0;
               busy_nxt = 1'b0;
               cnt_nxt  = 8'd0;
            end
         end
         ST_GRANT: begin
            if (release_s) begin
               gnt_nxt  = 8'd0;
               busy_nxt = 1'b0;
               cnt_nxt  = 8'd0;
            end else if (cnt_r != 8'hFF) begin
               cnt_nxt  = cnt_r + 8'd1;
            end else begin
               cnt_nxt  = cnt_r;
            end
         end
         default: begin
            gnt_nxt  = 8'd0;
            busy_nxt = 1'b0;
            cnt_nxt  = 8'd0;
         end
      endcase
   end

   assign gnt  = gnt_r;
   assign sel  = sel_r;
   assign busy = busy_r;

endmodule

// File: tb/tb_mux8_bus_arbiter.sv
// Directed bench for mux8_bus_arbiter (instance built with MAX_HOLD=4).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. they show the result of the edge just taken.

module tb_mux8_bus_arbiter;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       busy;

   int n_assert = 0;
   int n_fail   = 0;

   mux8_bus_arbiter #(.MAX_HOLD(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .done (done),
      .gnt  (gnt),
      .sel  (sel),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] eg, input logic [2:0] es, input logic eb);
      n_assert++;
      assert (gnt === eg) else begin
         n_fail++;
         $error("FAIL %s gnt=%h expected %h", tag, gnt, eg);
      end
      n_assert++;
      assert (sel === es) else begin
         n_fail++;
         $error("FAIL %s sel=%0d expected %0d", tag, sel, es);
      end
      n_assert++;
      assert (busy === eb) else begin
         n_fail++;
         $error("FAIL %s busy=%b expected %b", tag, busy, eb);
      end
   endtask

   initial begin
      rst  = 1'b1;
      req  = 8'hFF;
      done = 1'b0;

      // Reset held two cycles with all requests pending.
      tick();
      tick();
      chk("reset", 8'h00, 3'd0, 1'b0);
      rst = 1'b0;
      tick();
      chk("first_grant", 8'h01, 3'd0, 1'b1);

      // Round robin with req=FF: owner 0 -> 1 -> ... -> 7 -> 0.
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("rr_hold%0d", k), 8'd1 << ((k - 1) % 8), 3'((k - 1) % 8), 1'b1);
         done = 1'b1;
         tick();
         done = 1'b0;
         chk($sformatf("rr_idle%0d", k), 8'h00, 3'((k - 1) % 8), 1'b0);
         tick();
         chk($sformatf("rr_grant%0d", k), 8'd1 << (k % 8), 3'(k % 8), 1'b1);
      end

      // Skip/wrap: owner 6, then req=21 -> 0 (scan 7,0), then 5.
      done = 1'b1;
      tick();
      done = 1'b0;
      req  = 8'h40;
      chk("pre6_idle", 8'h00, 3'd0, 1'b0);
      tick();
      chk("grant6", 8'h40, 3'd6, 1'b1);
      req = 8'h21;
      tick();
      chk("drop6_idle", 8'h00, 3'd6, 1'b0);
      tick();
      chk("wrap_grant0", 8'h01, 3'd0, 1'b1);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("wrap_idle", 8'h00, 3'd0, 1'b0);
      tick();
      chk("grant5", 8'h20, 3'd5, 1'b1);

      // Hold limit 4: owner 3 holds exactly four cycles, one idle, regrant.
      done = 1'b1;
      tick();
      done = 1'b0;
      req  = 8'h08;
      chk("pre3_idle", 8'h00, 3'd5, 1'b0);
      tick();
      chk("hold_c1", 8'h08, 3'd3, 1'b1);
      for (int j = 2; j <= 4; j++) begin
         tick();
         chk($sformatf("hold_c%0d", j), 8'h08, 3'd3, 1'b1);
      end
      tick();
      chk("hold_expire", 8'h00, 3'd3, 1'b0);
      tick();
      chk("hold_regrant", 8'h08, 3'd3, 1'b1);

      // Request drop by owner 2, then a stray done in IDLE.
      req = 8'h04;
      tick();
      chk("pre2_idle", 8'h00, 3'd3, 1'b0);
      tick();
      chk("grant2", 8'h04, 3'd2, 1'b1);
      tick();
      chk("grant2_hold", 8'h04, 3'd2, 1'b1);
      req = 8'h00;
      tick();
      chk("drop2_idle", 8'h00, 3'd2, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("stray_done", 8'h00, 3'd2, 1'b0);
      tick();
      chk("stray_after", 8'h00, 3'd2, 1'b0);

      // Reset mid-grant, then req=11 -> owner 0 from a cleared pointer.
      req = 8'h10;
      tick();
      chk("grant4", 8'h10, 3'd4, 1'b1);
      rst = 1'b1;
      tick();
      chk("mid_reset", 8'h00, 3'd0, 1'b0);
      rst = 1'b0;
      req = 8'h11;
      tick();
      chk("post_reset0", 8'h01, 3'd0, 1'b1);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("post_reset_idle", 8'h00, 3'd0, 1'b0);
      tick();
      chk("post_reset4", 8'h10, 3'd4, 1'b1);

      // Second mid-grant reset (pointer was 5): req=30 must pick 4, not 5.
      rst = 1'b1;
      tick();
      chk("mid_reset2", 8'h00, 3'd0, 1'b0);
      rst = 1'b0;
      req = 8'h30;
      tick();
      chk("ptr_cleared", 8'h10, 3'd4, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
